// File: rtl/op_buffer.sv
// rtl/op_buffer.sv - circular operand side-buffer with in-order alloc/commit, squash and indexed reads
module op_buffer #(
    parameter  int DEPTH   = 32,
    parameter  int WIDTH   = 64,
    parameter  int ENQ_NUM = 4,
    parameter  int RD_NUM  = 3,
    parameter  int DEQ_NUM = 4,
    localparam int IW      = $clog2(DEPTH) + 1,
    localparam int DW      = $clog2(DEQ_NUM + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ENQ_NUM-1:0]                i_enq_req,
    input  logic [ENQ_NUM-1:0][WIDTH-1:0]     i_enq_data,
    output logic                              o_can_enq,
    output logic [ENQ_NUM-1:0][IW-1:0]        o_enq_idx,
    input  logic [RD_NUM-1:0]                 i_rd_vld,
    input  logic [RD_NUM-1:0][IW-1:0]         i_rd_idx,
    output logic [RD_NUM-1:0]                 o_rd_vld,
    output logic [RD_NUM-1:0][WIDTH-1:0]      o_rd_data,
    input  logic [DW-1:0]                     i_deq_num,
    input  logic                              i_squash_vld,
    input  logic [IW-1:0]                     i_squash_idx,
    output logic [IW-1:0]                     o_count,
    output logic                              o_empty,
    output logic                              o_full
);

    localparam int AW = IW - 1;
    localparam logic [IW-1:0] ONE_IW   = IW'(1);
    localparam logic [IW-1:0] DEPTH_IW = IW'(DEPTH);
    localparam logic [IW-1:0] ENQ_IW   = IW'(ENQ_NUM);

    logic [IW-1:0]                 head_q, head_d;
    logic [IW-1:0]                 tail_q, tail_d;
    logic [RD_NUM-1:0]             rd_vld_q, rd_vld_d;
    logic [RD_NUM-1:0][WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [WIDTH-1:0]              mem_q [DEPTH];

    logic [IW-1:0] count;
    logic [IW-1:0] enq_total;
    logic [IW-1:0] deq_ext;
    logic [IW-1:0] deq_eff;
    logic          enq_fire;

    // Occupancy and flags come only from the registered pointers; the MSB wrap flag separates full from empty.
    always_comb begin
        count     = tail_q - head_q;
        o_empty   = (tail_q == head_q);
        o_full    = (tail_q[AW-1:0] == head_q[AW-1:0]) && (tail_q[AW] != head_q[AW]);
        o_can_enq = ((DEPTH_IW - count) >= ENQ_IW) && !i_squash_vld;
        o_count   = count;
    end

    // Compact requesting lanes onto consecutive indices starting at tail.
    always_comb begin
        enq_total = '0;
        for (int k = 0; k < ENQ_NUM; k++) begin
            o_enq_idx[k] = tail_q + enq_total;
            if (i_enq_req[k]) begin
                enq_total = enq_total + ONE_IW;
            end
        end
        enq_fire = o_can_enq;
    end

    // Pointer next-state: commit is clamped to occupancy; squash overrides allocation.
    always_comb begin
        deq_ext = {{(IW-DW){1'b0}}, i_deq_num};
        deq_eff = (deq_ext > count) ? count : deq_ext;
        head_d  = head_q + deq_eff;
        tail_d  = tail_q;
        if (i_squash_vld) begin
            tail_d = i_squash_idx;
        end else if (enq_fire) begin
            tail_d = tail_q + enq_total;
        end
    end

    // Read ports: storage lookup, with same-cycle accepted enqueue data taking priority.
    always_comb begin
        rd_vld_d  = i_rd_vld;
        rd_data_d = rd_data_q;
        for (int p = 0; p < RD_NUM; p++) begin
            if (i_rd_vld[p]) begin
                rd_data_d[p] = mem_q[i_rd_idx[p][AW-1:0]];
                for (int k = 0; k < ENQ_NUM; k++) begin
                    if (enq_fire && i_enq_req[k] &&
                        (o_enq_idx[k][AW-1:0] == i_rd_idx[p][AW-1:0])) begin
                        rd_data_d[p] = i_enq_data[k];
                    end
                end
            end
        end
    end

    // Pointer and read-output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            rd_vld_q  <= '0;
            rd_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Payload storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_NUM; k++) begin
            if (enq_fire && i_enq_req[k]) begin
                mem_q[o_enq_idx[k][AW-1:0]] <= i_enq_data[k];
            end
        end
    end

    assign o_rd_vld  = rd_vld_q;
    assign o_rd_data = rd_data_q;

`ifndef SYNTHESIS
    logic [IW-1:0] squash_off;
    assign squash_off = i_squash_idx - head_q;

    a_deq_le_count: assert property (@(posedge clk) disable iff (!rst)
        deq_ext <= count);
    a_squash_in_range: assert property (@(posedge clk) disable iff (!rst)
        i_squash_vld |-> (squash_off <= count));
`endif

endmodule

// File: tb/tb_op_buffer.sv
// tb/tb_op_buffer.sv - directed self-checking bench for op_buffer
module tb_op_buffer;

    localparam int DEPTH = 32, WIDTH = 64, ENQ_NUM = 4, RD_NUM = 3, DEQ_NUM = 4;
    localparam int IW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(DEQ_NUM + 1);

    logic                              clk;
    logic                              rst;
    logic [ENQ_NUM-1:0]                i_enq_req;
    logic [ENQ_NUM-1:0][WIDTH-1:0]     i_enq_data;
    logic                              o_can_enq;
    logic [ENQ_NUM-1:0][IW-1:0]        o_enq_idx;
    logic [RD_NUM-1:0]                 i_rd_vld;
    logic [RD_NUM-1:0][IW-1:0]         i_rd_idx;
    logic [RD_NUM-1:0]                 o_rd_vld;
    logic [RD_NUM-1:0][WIDTH-1:0]      o_rd_data;
    logic [DW-1:0]                     i_deq_num;
    logic                              i_squash_vld;
    logic [IW-1:0]                     i_squash_idx;
    logic [IW-1:0]                     o_count;
    logic                              o_empty;
    logic                              o_full;

    int vectors;
    int miscompares;

    op_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ENQ_NUM(ENQ_NUM), .RD_NUM(RD_NUM), .DEQ_NUM(DEQ_NUM)) dut (
        .clk(clk), .rst(rst),
        .i_enq_req(i_enq_req), .i_enq_data(i_enq_data),
        .o_can_enq(o_can_enq), .o_enq_idx(o_enq_idx),
        .i_rd_vld(i_rd_vld), .i_rd_idx(i_rd_idx),
        .o_rd_vld(o_rd_vld), .o_rd_data(o_rd_data),
        .i_deq_num(i_deq_num),
        .i_squash_vld(i_squash_vld), .i_squash_idx(i_squash_idx),
        .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_enq_req    = '0;
        i_enq_data   = '0;
        i_rd_vld     = '0;
        i_rd_idx     = '0;
        i_deq_num    = '0;
        i_squash_vld = 1'b0;
        i_squash_idx = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic enq_cycles(input int n, input logic [ENQ_NUM-1:0] req, input logic [WIDTH-1:0] base);
        for (int c = 0; c < n; c++) begin
            i_enq_req = req;
            for (int k = 0; k < ENQ_NUM; k++) i_enq_data[k] = base + WIDTH'(c * 16 + k);
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (o_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %0b exp 1", o_empty); end
        vectors++; if (o_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b exp 0", o_full); end
        vectors++; if (o_can_enq !== 1'b1) begin miscompares++; $display("FAIL reset_can_enq got %0b exp 1", o_can_enq); end
        vectors++; if (o_count !== 6'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", o_count); end
        vectors++; if (o_rd_vld !== 3'b000) begin miscompares++; $display("FAIL reset_rd_vld got %0b exp 0", o_rd_vld); end
        vectors++; if (o_rd_data[0] !== 64'h0) begin miscompares++; $display("FAIL reset_rd_data got %0h exp 0", o_rd_data[0]); end
    endtask

    task automatic test_enq_read();
        i_enq_req = 4'b1111;
        for (int k = 0; k < 4; k++) i_enq_data[k] = 64'h10 + 64'(k);
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (o_enq_idx[k] !== 6'(k)) begin miscompares++; $display("FAIL enq4_idx lane%0d got %0d exp %0d", k, o_enq_idx[k], k); end
        end
        tick();
        idle();
        vectors++; if (o_count !== 6'd4) begin miscompares++; $display("FAIL enq4_count got %0d exp 4", o_count); end
        vectors++; if (o_empty !== 1'b0) begin miscompares++; $display("FAIL enq4_empty got %0b exp 0", o_empty); end
        i_rd_vld = 3'b001;
        i_rd_idx[0] = 6'd2;
        tick();
        idle();
        vectors++; if (o_rd_data[0] !== 64'h12) begin miscompares++; $display("FAIL read_idx2 got %0h exp 12", o_rd_data[0]); end
        vectors++; if (o_rd_vld !== 3'b001) begin miscompares++; $display("FAIL read_vld got %0b exp 001", o_rd_vld); end
    endtask

    task automatic test_holes();
        i_enq_req = 4'b0001;
        i_enq_data[0] = 64'h14;
        tick();
        i_enq_req = 4'b1010;
        i_enq_data[1] = 64'h15;
        i_enq_data[3] = 64'h16;
        #1;
        vectors++; if (o_enq_idx[1] !== 6'd5) begin miscompares++; $display("FAIL holes_lane1 got %0d exp 5", o_enq_idx[1]); end
        vectors++; if (o_enq_idx[3] !== 6'd6) begin miscompares++; $display("FAIL holes_lane3 got %0d exp 6", o_enq_idx[3]); end
        tick();
        idle();
        #1;
        vectors++; if (o_count !== 6'd7) begin miscompares++; $display("FAIL holes_count got %0d exp 7", o_count); end
        vectors++; if (o_enq_idx[0] !== 6'd7) begin miscompares++; $display("FAIL holes_tail got %0d exp 7", o_enq_idx[0]); end
        i_rd_vld = 3'b010;
        i_rd_idx[1] = 6'd6;
        tick();
        idle();
        vectors++; if (o_rd_data[1] !== 64'h16) begin miscompares++; $display("FAIL holes_read6 got %0h exp 16", o_rd_data[1]); end
    endtask

    task automatic test_full();
        do_reset();
        enq_cycles(8, 4'b1111, 64'h100);
        vectors++; if (o_count !== 6'd32) begin miscompares++; $display("FAIL full_count got %0d exp 32", o_count); end
        vectors++; if (o_full !== 1'b1) begin miscompares++; $display("FAIL full_flag got %0b exp 1", o_full); end
        vectors++; if (o_can_enq !== 1'b0) begin miscompares++; $display("FAIL full_can_enq got %0b exp 0", o_can_enq); end
        enq_cycles(1, 4'b1111, 64'h900);
        vectors++; if (o_count !== 6'd32) begin miscompares++; $display("FAIL full_ignore_count got %0d exp 32", o_count); end
        i_rd_vld = 3'b001;
        i_rd_idx[0] = 6'd1;
        tick();
        idle();
        vectors++; if (o_rd_data[0] !== 64'h101) begin miscompares++; $display("FAIL full_ignore_data got %0h exp 101", o_rd_data[0]); end
        i_deq_num = 3'd4;
        i_enq_req = 4'b1111;
        #1;
        vectors++; if (o_can_enq !== 1'b0) begin miscompares++; $display("FAIL full_deq_same_cycle got %0b exp 0", o_can_enq); end
        tick();
        idle();
        vectors++; if (o_count !== 6'd28) begin miscompares++; $display("FAIL full_deq_count got %0d exp 28", o_count); end
        vectors++; if (o_can_enq !== 1'b1) begin miscompares++; $display("FAIL full_deq_can_enq got %0b exp 1", o_can_enq); end
        vectors++; if (o_full !== 1'b0) begin miscompares++; $display("FAIL full_deq_flag got %0b exp 0", o_full); end
    endtask

    task automatic test_wrap();
        do_reset();
        enq_cycles(7, 4'b1111, 64'h200);
        enq_cycles(1, 4'b0011, 64'h300);
        for (int c = 0; c < 7; c++) begin
            i_deq_num = 3'd4;
            tick();
        end
        i_deq_num = 3'd2;
        tick();
        idle();
        vectors++; if (o_empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty got %0b exp 1", o_empty); end
        i_enq_req = 4'b1111;
        for (int k = 0; k < 4; k++) i_enq_data[k] = 64'hA0 + 64'(k);
        #1;
        vectors++; if (o_enq_idx[0] !== 6'd30) begin miscompares++; $display("FAIL wrap_idx0 got %0d exp 30", o_enq_idx[0]); end
        vectors++; if (o_enq_idx[1] !== 6'd31) begin miscompares++; $display("FAIL wrap_idx1 got %0d exp 31", o_enq_idx[1]); end
        vectors++; if (o_enq_idx[2] !== 6'd32) begin miscompares++; $display("FAIL wrap_idx2 got %0d exp 32", o_enq_idx[2]); end
        vectors++; if (o_enq_idx[3] !== 6'd33) begin miscompares++; $display("FAIL wrap_idx3 got %0d exp 33", o_enq_idx[3]); end
        tick();
        idle();
        i_rd_vld = 3'b011;
        i_rd_idx[0] = 6'd33;
        i_rd_idx[1] = 6'd32;
        tick();
        idle();
        vectors++; if (o_rd_data[0] !== 64'hA3) begin miscompares++; $display("FAIL wrap_read33 got %0h exp a3", o_rd_data[0]); end
        vectors++; if (o_rd_data[1] !== 64'hA2) begin miscompares++; $display("FAIL wrap_read32 got %0h exp a2", o_rd_data[1]); end
        vectors++; if (o_count !== 6'd4) begin miscompares++; $display("FAIL wrap_count got %0d exp 4", o_count); end
    endtask

    task automatic test_squash_fwd();
        do_reset();
        enq_cycles(2, 4'b1111, 64'h400);
        enq_cycles(1, 4'b0011, 64'h500);
        i_deq_num = 3'd2;
        tick();
        idle();
        vectors++; if (o_count !== 6'd8) begin miscompares++; $display("FAIL squash_pre_count got %0d exp 8", o_count); end
        i_squash_vld = 1'b1;
        i_squash_idx = 6'd6;
        i_deq_num    = 3'd2;
        i_enq_req    = 4'b1111;
        for (int k = 0; k < 4; k++) i_enq_data[k] = 64'hDEAD0 + 64'(k);
        #1;
        vectors++; if (o_can_enq !== 1'b0) begin miscompares++; $display("FAIL squash_can_enq got %0b exp 0", o_can_enq); end
        tick();
        idle();
        vectors++; if (o_count !== 6'd2) begin miscompares++; $display("FAIL squash_count got %0d exp 2", o_count); end
        i_enq_req = 4'b0001;
        i_enq_data[0] = 64'h55;
        #1;
        vectors++; if (o_enq_idx[0] !== 6'd6) begin miscompares++; $display("FAIL squash_tail got %0d exp 6", o_enq_idx[0]); end
        tick();
        idle();
        i_enq_req = 4'b0010;
        i_enq_data[1] = 64'hBEEF;
        i_rd_vld = 3'b100;
        i_rd_idx[2] = 6'd7;
        #1;
        vectors++; if (o_enq_idx[1] !== 6'd7) begin miscompares++; $display("FAIL fwd_idx got %0d exp 7", o_enq_idx[1]); end
        tick();
        idle();
        vectors++; if (o_rd_data[2] !== 64'hBEEF) begin miscompares++; $display("FAIL fwd_data got %0h exp beef", o_rd_data[2]); end
        vectors++; if (o_rd_vld !== 3'b100) begin miscompares++; $display("FAIL fwd_vld got %0b exp 100", o_rd_vld); end
        vectors++; if (o_count !== 6'd4) begin miscompares++; $display("FAIL fwd_count got %0d exp 4", o_count); end
        i_rd_vld = 3'b100;
        i_rd_idx[2] = 6'd7;
        tick();
        i_rd_vld = 3'b001;
        i_rd_idx[0] = 6'd6;
        rst = 1'b0;
        #1;
        vectors++; if (o_rd_vld !== 3'b000) begin miscompares++; $display("FAIL rst_mid_rd_vld got %0b exp 000", o_rd_vld); end
        vectors++; if (o_count !== 6'd0) begin miscompares++; $display("FAIL rst_mid_count got %0d exp 0", o_count); end
        vectors++; if (o_empty !== 1'b1) begin miscompares++; $display("FAIL rst_mid_empty got %0b exp 1", o_empty); end
        idle();
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        idle();
        test_reset();
        test_enq_read();
        test_holes();
        test_full();
        test_wrap();
        test_squash_fwd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/op_buffer.md
# op_buffer

Parametrised circular side-buffer that holds per-instruction operands too wide for the issue queues (PC/NPC pairs for the branch unit, 20-bit immediates for imm-ops). Dispatch allocates entries in program order and hands each instruction an index, which it carries through the RS. The issue/execute stage reads entries by index through several read ports. Commit frees entries in order, and a squash rolls the allocation pointer back. One instance serves as the PC buffer and another as the imm buffer, replacing the separate fixed-size buffers.

## Interface
Parameters:
- DEPTH, 32, entry count, power of two, ≥ ENQ_NUM
- WIDTH, 64, payload bits per entry
- ENQ_NUM, 4, allocation lanes per cycle
- RD_NUM, 3, random-access read ports
- DEQ_NUM, 4, max entries freed per cycle
- IW (derived), $clog2(DEPTH)+1, index width: MSB is the wrap flag, LSBs address the entry

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_enq_req  in  ENQ_NUM  per-lane allocate request
- i_enq_data  in  ENQ_NUM×WIDTH  per-lane payload
- o_can_enq  out  1  free ≥ ENQ_NUM and no squash this cycle
- o_enq_idx  out  ENQ_NUM×IW  index assigned to each lane, valid for lanes with req set
- i_rd_vld  in  RD_NUM  read request
- i_rd_idx  in  RD_NUM×IW  read index
- o_rd_vld  out  RD_NUM  read data valid
- o_rd_data  out  RD_NUM×WIDTH  read data
- i_deq_num  in  $clog2(DEQ_NUM+1)  oldest entries committed this cycle
- i_squash_vld  in  1  squash request
- i_squash_idx  in  IW  first (oldest) index to discard
- o_count  out  $clog2(DEPTH)+1  occupied entries
- o_empty  out  1  count == 0
- o_full  out  1  count == DEPTH

## Operation
- State: head, tail (IW bits each, wrap-flag pointers), count, storage array (not reset), read-output registers.
- Reset: head = tail = 0, count = 0, o_rd_vld = 0, o_rd_data = 0. Outputs follow: o_empty = 1, o_full = 0, o_can_enq = 1.
- Allocation, lanes compacted:
  - lane k gets o_enq_idx[k] = tail + popcount(i_enq_req[k-1:0]), modulo 2·DEPTH.
  - Holes in i_enq_req are legal.
  - Requests are accepted only when o_can_enq = 1. Otherwise they are ignored, and the caller must hold them.
  - On acceptance, tail += popcount(i_enq_req) and data is written at each assigned index.
- Read: on i_rd_vld[p], the entry at i_rd_idx[p] low bits is registered into o_rd_data[p], and o_rd_vld[p] = i_rd_vld[p].
  - If an accepted same-cycle enqueue targets that index, the enqueue data is forwarded (write-first).
- Commit: head += i_deq_num.
  - If i_deq_num > count, the count is clamped to count, and a simulation assertion fires.
- Squash: tail ← i_squash_idx, and enqueue is suppressed that cycle.
  - i_squash_idx must satisfy head ≤ idx ≤ tail in wrap-flag order. Violations fire an assertion.
  - idx == tail is a no-op squash.
  - A commit in the same cycle still applies: head advances, and the new count = i_squash_idx − (head + deq).
- count = tail − head (IW-bit subtraction). count and the flags are derived from registered pointers.
- Full/empty disambiguation uses the wrap flag: equal LSBs with differing MSB means full.

## Timing
- o_enq_idx and o_can_enq: combinational, same cycle as i_enq_req (o_can_enq depends on registered count and i_squash_vld only).
- Enqueued data is readable by a read issued in the same cycle (forwarded) or later. o_rd_data appears at the next edge (1-cycle latency).
- Pointer, count and flag updates are visible the cycle after enq, deq or squash.
- A freed entry may be reallocated the cycle after commit. Free space is not reused in the same cycle.
- Asserting rst mid-operation clears pointers and o_rd_vld immediately. Storage contents are undefined after reset.

## Test plan
- Reset then 4 lanes with req=4'b1111, data 0x10..0x13 → o_enq_idx = 0,1,2,3; next cycle o_count=4; read idx 2 → o_rd_data=0x12 one cycle later.
- Holed request req=4'b1010 with tail=5 → lane1 idx 5, lane3 idx 6; tail becomes 7.
- Fill to 32 (8 cycles × 4) → o_full=1, o_can_enq=0; further requests are ignored; deq_num=4 → o_count=28 next cycle, o_can_enq=1.
- Wrap: head=30, tail=30, enqueue 4 → indices 30,31,32(flag=1,addr 0),33; read idx 33 returns lane-3 data.
- Squash with head=2, tail=10, i_squash_idx=6 and i_deq_num=2 in the same cycle, plus enq request → head=4, tail=6, o_count=2; enqueue is dropped and o_can_enq=0 that cycle.
- Same-cycle enqueue at idx 7 with read of idx 7 → o_rd_data equals the new payload next cycle. Asserting rst during the read → o_rd_vld=0 and o_count=0.
